pid_axis_scheduler: RTL
=======================

# pid_axis_scheduler

Time-multiplexes one single-axis rate PID engine across the roll, pitch and yaw axes. On each `frame_start` it snapshots all three axes' operands and runs the PID once per axis, in the order roll, pitch, yaw. It captures each clamped rate and publishes all three together with a one-cycle `rates_valid` strobe. It sits between the attitude/angle stage and the motor mixer and owns the PID engine's start/wait handshake.

## Interface
- `DATA_W`, default 16: width of all operand and rate words (two's complement).
- `TIMEOUT_CYCLES`, default 64: maximum cycles allowed per handshake phase before the axis is abandoned.
- `us_clk` input, 1: system clock.
- `resetn` input, 1: asynchronous, active-low reset.
- `frame_start` input, 1: single-cycle request to run one full three-axis frame.
- `target_{roll,pitch,yaw}` input, DATA_W, signed: target rotation rate per axis.
- `actual_{roll,pitch,yaw}` input, DATA_W, signed: measured rotation rate per axis.
- `angle_err_{roll,pitch,yaw}` input, DATA_W, signed: angle error per axis.
- `pid_target`, `pid_actual`, `pid_angle_error` output, DATA_W: muxed operands sent to the PID engine.
- `pid_start` output, 1: start request to the PID engine.
- `pid_wait` output, 1: release request; returns the engine to its idle state.
- `pid_rate` input, DATA_W: clamped rate from the PID engine.
- `pid_active` input, 1: engine busy; high from the first calculation cycle until it returns to idle.
- `pid_complete` input, 1: result valid (meaningful only while `pid_active`=1).
- `roll_rate`, `pitch_rate`, `yaw_rate` output, DATA_W: published rates.
- `rates_valid` output, 1: one-cycle strobe when all three rates update.
- `busy` output, 1: a frame is in progress.
- `frame_overrun` output, 1: one-cycle pulse when `frame_start` arrives while a request is already pending.
- `pid_timeout` output, 1: sticky flag; set on any handshake timeout and cleared only by reset.

## Operation
- Reset values: all rate outputs and `pid_*` operands are 0; `pid_start`, `pid_wait`, `rates_valid`, `busy`, `frame_overrun` and `pid_timeout` are 0. State is IDLE, axis index is 0, pending flag is 0.
- States and transitions:
  - **IDLE**: on `frame_start`, or when the pending flag is set, go to SNAP.
  - **SNAP**: register all nine operand inputs into a shadow bank. Set axis=0 and `busy`=1. Go to LOAD.
  - **LOAD**: drive `pid_*` operands from the shadow bank selected by the axis index. Go to START.
  - **START**: hold `pid_start`=1 until `pid_active`=1, then drop it and go to RUN.
  - **RUN**: wait for `pid_active`=1 and `pid_complete`=1 together. Then latch `pid_rate` into the axis result register and go to RELEASE.
  - **RELEASE**: hold `pid_wait`=1 until `pid_active`=0, then drop it. If axis<2, increment axis and go to LOAD; otherwise go to DONE.
  - **DONE**: copy the three result registers to the rate outputs, pulse `rates_valid`, clear `busy`, go to IDLE.
- Operands stay constant on `pid_*` from LOAD until the axis leaves RELEASE. Input changes during a frame have no effect.
- `frame_start` while `busy`=1 sets the pending flag, so one request is queued. If the pending flag is already set, the request is dropped and `frame_overrun` pulses.
- `frame_start` in the same cycle as the transition from DONE to IDLE is treated as pending. The next frame starts on the following cycle.
- Timeout handling:
  - A watchdog counter clears on every state entry.
  - If START, RUN or RELEASE reaches `TIMEOUT_CYCLES` cycles, set `pid_timeout`.
  - The axis result register keeps its previous value.
  - Force `pid_start`=0 and `pid_wait`=1 for one cycle, then continue to the next axis (or to DONE).
- The rate outputs change only in DONE; the three axes always update atomically.
- Reset mid-frame returns everything to reset values immediately. A partially computed frame is never published.

## Timing
- `pid_start`, `pid_wait` and the operands are registered outputs; handshake inputs are sampled on the `us_clk` rising edge.
- With a PID engine that raises `pid_active` 2 cycles after start, completes 4 cycles later, and drops `pid_active` 1 cycle after wait, one axis takes 10 cycles (LOAD through RELEASE exit).
- For that engine, `rates_valid` follows `frame_start` by 1 (SNAP) + 3×10 + 1 (DONE) = 32 cycles.
- Minimum frame-to-frame spacing is 33 cycles; a closer `frame_start` is queued.
- `busy` rises in the cycle after `frame_start` and falls together with the `rates_valid` pulse.

## Test plan
- **Single frame.** Behavioural PID model returns target−actual. Apply targets (100, −50, 0) and actuals (40, −60, 5) → rates (60, 10, −5) and one `rates_valid` 32 cycles after `frame_start`.
- **Operand isolation.** Change all inputs to 0x7FFF one cycle after `frame_start` → published rates still come from the snapshot values; `pid_*` is stable across each START..RELEASE window.
- **Queueing.** Pulse `frame_start` at cycles 0, 5 and 10 → two frames run back to back, one `frame_overrun` pulse at cycle 10, and exactly two `rates_valid` pulses.
- **Timeout.** Hold `pid_active`=0 on the pitch axis → `pid_timeout`=1 after 64 cycles; pitch_rate keeps its old value; roll and yaw update; `rates_valid` still pulses.
- **Reset mid-frame.** Assert `resetn`=0 during yaw RUN → all outputs read 0 immediately, no `rates_valid`, and a fresh `frame_start` after reset produces correct rates.
- **Clamp passthrough.** Model returns 0x8000 on roll and 0x7FFF on yaw → the published values are exactly 0x8000 and 0x7FFF.

Source files
------------

// File: rtl/pid_axis_scheduler.sv
// pid_axis_scheduler: runs one rate PID engine over roll, pitch and yaw per frame and publishes the three rates atomically.
module pid_axis_scheduler #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     us_clk,
  input  logic                     resetn,
  input  logic                     frame_start,
  input  logic signed [DATA_W-1:0] target_roll,
  input  logic signed [DATA_W-1:0] target_pitch,
  input  logic signed [DATA_W-1:0] target_yaw,
  input  logic signed [DATA_W-1:0] actual_roll,
  input  logic signed [DATA_W-1:0] actual_pitch,
  input  logic signed [DATA_W-1:0] actual_yaw,
  input  logic signed [DATA_W-1:0] angle_err_roll,
  input  logic signed [DATA_W-1:0] angle_err_pitch,
  input  logic signed [DATA_W-1:0] angle_err_yaw,
  output logic        [DATA_W-1:0] pid_target,
  output logic        [DATA_W-1:0] pid_actual,
  output logic        [DATA_W-1:0] pid_angle_error,
  output logic                     pid_start,
  output logic                     pid_wait,
  input  logic        [DATA_W-1:0] pid_rate,
  input  logic                     pid_active,
  input  logic                     pid_complete,
  output logic        [DATA_W-1:0] roll_rate,
  output logic        [DATA_W-1:0] pitch_rate,
  output logic        [DATA_W-1:0] yaw_rate,
  output logic                     rates_valid,
  output logic                     busy,
  output logic                     frame_overrun,
  output logic                     pid_timeout
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SNAP, LOAD, START, RUN, RELEASE, ABORT, DONE} state_t;
  state_t state, nxt;
  logic [1:0] axis, li;
  logic pend, expired;
  logic [WD_W-1:0] wd;
  logic [DATA_W-1:0] sh_t [3];
  logic [DATA_W-1:0] sh_a [3];
  logic [DATA_W-1:0] sh_e [3];
  logic [DATA_W-1:0] res  [3];
  assign expired = wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign li = (state == SNAP) ? 2'd0 : axis + 2'd1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (frame_start || pend) ? SNAP : IDLE;
      SNAP:    nxt = LOAD;
      LOAD:    nxt = START;
      START:   nxt = pid_active ? RUN : expired ? ABORT : START;
      RUN:     nxt = (pid_active && pid_complete) ? RELEASE : expired ? ABORT : RUN;
      RELEASE: nxt = !pid_active ? ((axis == 2'd2) ? DONE : LOAD) : expired ? ABORT : RELEASE;
      ABORT:   nxt = (axis == 2'd2) ? DONE : LOAD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they are registered yet aligned with the state they belong to.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      axis            <= '0;
      pend            <= 1'b0;
      wd              <= '0;
      pid_start       <= 1'b0;
      pid_wait        <= 1'b0;
      pid_target      <= '0;
      pid_actual      <= '0;
      pid_angle_error <= '0;
      roll_rate       <= '0;
      pitch_rate      <= '0;
      yaw_rate        <= '0;
      rates_valid     <= 1'b0;
      busy            <= 1'b0;
      frame_overrun   <= 1'b0;
      pid_timeout     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sh_t[i] <= '0;
        sh_a[i] <= '0;
        sh_e[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      state         <= nxt;
      wd            <= (nxt != state) ? '0 : wd + 1'b1;
      pid_start     <= nxt == START;
      pid_wait      <= nxt == RELEASE || nxt == ABORT;
      rates_valid   <= nxt == DONE;
      frame_overrun <= frame_start && state != IDLE && pend;
      if (state == IDLE && nxt == SNAP) pend <= 1'b0;
      else if (frame_start && state != IDLE) pend <= 1'b1;
      if (nxt == ABORT) pid_timeout <= 1'b1;
      // Snapshot on the edge that accepts the request so later input changes cannot leak in.
      if (nxt == SNAP) begin
        busy    <= 1'b1;
        sh_t[0] <= target_roll;
        sh_t[1] <= target_pitch;
        sh_t[2] <= target_yaw;
        sh_a[0] <= actual_roll;
        sh_a[1] <= actual_pitch;
        sh_a[2] <= actual_yaw;
        sh_e[0] <= angle_err_roll;
        sh_e[1] <= angle_err_pitch;
        sh_e[2] <= angle_err_yaw;
      end
      if (nxt == LOAD) begin
        axis            <= li;
        pid_target      <= sh_t[li];
        pid_actual      <= sh_a[li];
        pid_angle_error <= sh_e[li];
      end
      if (state == RUN && nxt == RELEASE) res[axis] <= pid_rate;
      if (nxt == DONE) begin
        busy       <= 1'b0;
        roll_rate  <= res[0];
        pitch_rate <= res[1];
        yaw_rate   <= res[2];
      end
    end
  end
endmodule
